// File: rtl/udma_crc_acc.sv
// Ultra DMA CRC accumulator/checker: seeds at burst start, folds each data word, compares with host CRC.
// Optional word counter enabled by defining UDMA_CRC_WORD_CNT_EN; otherwise word_cnt is tied to zero.
module udma_crc_acc #(
  parameter logic [15:0] SEED = 16'h4ABA
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        burst_start,
  input  logic        burst_end,
  input  logic        burst_abort,
  input  logic        word_vld,
  input  logic [15:0] word,
  input  logic        host_crc_vld,
  input  logic [15:0] host_crc,
  input  logic        err_clr,
  output logic [15:0] crc,
  output logic        busy,
  output logic        crc_done,
  output logic        crc_ok,
  output logic        crc_err,
  output logic [15:0] word_cnt
);

  typedef enum logic [1:0] {IDLE, BURST, CHECK} state_t;

  state_t      state;
  logic        seed_load;
  logic        fold;
  logic [15:0] crc_base;
  logic [15:0] crc_next;

  // Parallel CRC step, G(X)=X16+X12+X5+1; data bit 0 enters first against CRC bit 15.
  function automatic logic [15:0] crc_step(input logic [15:0] d, input logic [15:0] c);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 0; i < 16; i++) begin
      fb    = r[15] ^ d[i];
      r     = {r[14:0], fb};
      r[5]  = r[5] ^ fb;
      r[12] = r[12] ^ fb;
    end
    return r;
  endfunction

  // NOTE: every signal assigned in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    seed_load = burst_start && !burst_abort && (state != CHECK);
    fold      = word_vld && (seed_load || (state == BURST && !burst_abort));
    crc_base  = seed_load ? SEED : crc;
    crc_next  = crc_step(word, crc_base);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      crc      <= SEED;
      busy     <= 1'b0;
      crc_done <= 1'b0;
      crc_ok   <= 1'b0;
      crc_err  <= 1'b0;
    end else begin
      crc_done <= 1'b0;
      // NOTE: a later non-blocking assignment to crc_err in the same cycle wins, giving set priority over clear.
      if (err_clr) crc_err <= 1'b0;

      if (fold)           crc <= crc_next;
      else if (seed_load) crc <= SEED;

      case (state)
        IDLE: begin
          if (seed_load) begin
            state  <= BURST;
            busy   <= 1'b1;
            crc_ok <= 1'b0;
          end
        end
        BURST: begin
          if (burst_abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (seed_load) begin
            crc_ok <= 1'b0;
          end else if (burst_end) begin
            state <= CHECK;
          end
        end
        CHECK: begin
          if (burst_abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (host_crc_vld) begin
            state    <= IDLE;
            busy     <= 1'b0;
            crc_done <= 1'b1;
            crc_ok   <= (host_crc == crc);
            if (host_crc != crc) crc_err <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef UDMA_CRC_WORD_CNT_EN
  logic [15:0] cnt;

  // Wraps silently at 16'hFFFF.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         cnt <= 16'h0000;
    else if (seed_load) cnt <= {15'd0, word_vld};
    else if (fold)      cnt <= cnt + 16'd1;
  end

  assign word_cnt = cnt;
`else
  assign word_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_udma_crc_acc.sv
// Self-checking bench for udma_crc_acc: scoreboard of expected check results plus direct state checks.
`timescale 1ns/1ps
module tb_udma_crc_acc;

`ifdef UDMA_CRC_WORD_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  typedef struct packed {
    logic ok;
    logic err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        burst_start = 1'b0, burst_end = 1'b0, burst_abort = 1'b0;
  logic        word_vld = 1'b0, host_crc_vld = 1'b0, err_clr = 1'b0;
  logic [15:0] word = '0, host_crc = '0, host_crc0 = '0;
  logic [15:0] crc, word_cnt, crc0, word_cnt0;
  logic        busy, crc_done, crc_ok, crc_err;
  logic        busy0, crc_done0, crc_ok0, crc_err0;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_done   = 0;
  logic        m_err    = 1'b0;
  logic [15:0] g;

  always #5 clk = ~clk;

  udma_crc_acc dut (
    .clk(clk), .rst_n(rst_n), .burst_start(burst_start), .burst_end(burst_end),
    .burst_abort(burst_abort), .word_vld(word_vld), .word(word),
    .host_crc_vld(host_crc_vld), .host_crc(host_crc), .err_clr(err_clr),
    .crc(crc), .busy(busy), .crc_done(crc_done), .crc_ok(crc_ok),
    .crc_err(crc_err), .word_cnt(word_cnt)
  );

  udma_crc_acc #(.SEED(16'h0000)) dut0 (
    .clk(clk), .rst_n(rst_n), .burst_start(burst_start), .burst_end(burst_end),
    .burst_abort(burst_abort), .word_vld(word_vld), .word(word),
    .host_crc_vld(host_crc_vld), .host_crc(host_crc0), .err_clr(err_clr),
    .crc(crc0), .busy(busy0), .crc_done(crc_done0), .crc_ok(crc_ok0),
    .crc_err(crc_err0), .word_cnt(word_cnt0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Bit-serial reference: shift left, feedback polynomial 0x1021, data bit 0 first.
  function automatic logic [15:0] ref_step(input logic [15:0] d, input logic [15:0] c);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 16; i++)
      r = {r[14:0], 1'b0} ^ (((r[15] ^ d[i]) == 1'b1) ? 16'h1021 : 16'h0000);
    return r;
  endfunction

  always @(negedge clk) begin
    if (crc_done) begin
      n_done++;
      if (sb.size() == 0) begin
        check("unexpected_done", {31'd0, crc_done}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_crc_ok", {31'd0, crc_ok}, {31'd0, e.ok});
        check("sb_crc_err", {31'd0, crc_err}, {31'd0, e.err});
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
    burst_start = 1'b0; burst_end = 1'b0; burst_abort = 1'b0;
    word_vld = 1'b0; host_crc_vld = 1'b0; err_clr = 1'b0;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic wait_sb(input string tag);
    int k;
    k = 0;
    while (sb.size() != 0 && k < 4) begin
      @(negedge clk);
      #1;
      k++;
    end
    check(tag, sb.size(), 0);
  endtask

  // Drive the host CRC in the CHECK state and record what the checker must report.
  task automatic host_check(input logic [15:0] hc, input logic [15:0] exp_crc, input logic clr);
    exp_t e;
    host_crc_vld = 1'b1;
    host_crc     = hc;
    err_clr      = clr;
    if (hc != exp_crc) m_err = 1'b1;
    else if (clr)      m_err = 1'b0;
    e.ok  = (hc == exp_crc);
    e.err = m_err;
    sb.push_back(e);
    next_cycle();
    wait_sb("done_seen");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    sample();
    check("rst_crc", crc, 16'h4ABA);
    check("rst_busy", busy, 0);
    check("rst_cnt", word_cnt, 0);
    check("rst_flags", {crc_done, crc_ok, crc_err}, 0);

    // Empty burst with correct host CRC.
    next_cycle(); burst_start = 1'b1;
    next_cycle(); sample();
    check("empty_busy", busy, 1);
    check("empty_crc", crc, 16'h4ABA);
    burst_end = 1'b1;
    next_cycle(); sample();
    host_check(16'h4ABA, 16'h4ABA, 1'b0);
    check("empty_cnt", word_cnt, 0);
    check("empty_busy_lo", busy, 0);

    // Single word; SEED=0 instance must give 16'h1B98.
    next_cycle(); burst_start = 1'b1;
    next_cycle(); word_vld = 1'b1; word = 16'h0001;
    next_cycle(); sample();
    check("seed0_crc", crc0, 16'h1B98);
    g = ref_step(16'h0001, 16'h4ABA);
    check("one_word_crc", crc, g);
    check("one_word_cnt", word_cnt, CNT_EN ? 1 : 0);
    burst_end = 1'b1;
    next_cycle(); sample();
    host_crc0 = 16'h1B98;
    host_check(g, g, 1'b0);
    check("seed0_ok", crc_ok0, 1);

    // Mismatch then clear.
    next_cycle(); burst_start = 1'b1;
    next_cycle(); burst_end = 1'b1;
    next_cycle(); sample();
    host_check(16'h4ABB, 16'h4ABA, 1'b0);
    repeat (3) sample();
    check("err_held", crc_err, 1);
    next_cycle(); err_clr = 1'b1; m_err = 1'b0;
    next_cycle(); sample();
    check("err_cleared", crc_err, 0);

    // Mismatch coincident with ERR_CLR: set wins.
    next_cycle(); burst_start = 1'b1;
    next_cycle(); burst_end = 1'b1;
    next_cycle(); sample();
    host_check(16'h0000, 16'h4ABA, 1'b1);
    sample();
    check("err_set_prio", crc_err, 1);
    next_cycle(); err_clr = 1'b1; m_err = 1'b0;

    // Start coincident with word: word folds into SEED.
    next_cycle(); burst_start = 1'b1; word_vld = 1'b1; word = 16'hBEEF;
    next_cycle(); sample();
    check("start_word_crc", crc, ref_step(16'hBEEF, 16'h4ABA));
    check("start_word_cnt", word_cnt, CNT_EN ? 1 : 0);
    check("start_word_err", crc_err, 0);
    burst_abort = 1'b1;
    next_cycle();

    // 1000-word back-to-back burst, last word with BURST_END.
    next_cycle(); burst_start = 1'b1;
    g = 16'h4ABA;
    for (int i = 0; i < 1000; i++) begin
      next_cycle();
      word_vld = 1'b1;
      word = 16'($urandom);
      g = ref_step(word, g);
      if (i == 999) burst_end = 1'b1;
    end
    next_cycle(); sample();
    check("long_crc", crc, g);
    check("long_cnt", word_cnt, CNT_EN ? 1000 : 0);
    // In CHECK, WORD_VLD and BURST_START are ignored.
    word_vld = 1'b1; word = 16'h1234; burst_start = 1'b1;
    next_cycle(); sample();
    check("check_ignore_crc", crc, g);
    check("check_busy", busy, 1);
    host_check(g, g, 1'b0);

    // Abort variant: no CRC_DONE, host CRC in IDLE ignored.
    begin
      int done_before;
      done_before = n_done;
      next_cycle(); burst_start = 1'b1;
      for (int i = 0; i < 50; i++) begin
        next_cycle(); word_vld = 1'b1; word = 16'($urandom);
      end
      burst_end = 1'b1; burst_abort = 1'b1;
      next_cycle(); sample();
      check("abort_busy", busy, 0);
      host_crc_vld = 1'b1; host_crc = crc;
      repeat (3) next_cycle();
      check("abort_no_done", n_done, done_before);
    end

    // Asynchronous reset mid-burst.
    next_cycle(); burst_start = 1'b1;
    next_cycle(); word_vld = 1'b1; word = 16'h5A5A;
    next_cycle(); word_vld = 1'b1; word = 16'hA5A5;
    #2 rst_n = 1'b0;
    #1;
    check("amid_rst_crc", crc, 16'h4ABA);
    check("amid_rst_busy", busy, 0);
    check("amid_rst_flags", {crc_done, crc_ok, crc_err}, 0);
    check("amid_rst_cnt", word_cnt, 0);
    next_cycle(); next_cycle();
    rst_n = 1'b1;
    repeat (3) sample();
    check("post_rst_busy", busy, 0);
    check("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
